design_36_host: RTL and testbench

DESIGN_36_HOST -- requirements
Module: design_36_host

---
 rtl/design_36_host.sv | 94 +++++++++
 tb/tb_design_36_host.sv | 183 ++++++++++++++++++
 2 files changed

// File: rtl/design_36_host.sv
// design_36_host: request/response wrapper that issues operands to a compute unit and waits for its result or a timeout
module design_36_host #(
  parameter int W       = 10,
  parameter int TIMEOUT = 15
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         req_valid,
  output logic         req_ready,
  input  logic [W-1:0] req_a,
  input  logic [W-1:0] req_b,
  output logic         dut_start,
  output logic [W-1:0] dut_a,
  output logic [W-1:0] dut_b,
  input  logic [W-1:0] dut_y,
  input  logic         dut_valid,
  output logic         rsp_valid,
  input  logic         rsp_ready,
  output logic [W-1:0] rsp_y,
  output logic         rsp_timeout,
  output logic         busy,
  output logic [7:0]   txn_count
);
  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;
  state_t state_q, state_d;
  logic [7:0] cnt_q, cnt_d, txn_q, txn_d;
  logic [W-1:0] a_q, a_d, b_q, b_d, y_q, y_d;
  logic to_q, to_d;
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    txn_d   = txn_q;
    a_d     = a_q;
    b_d     = b_q;
    y_d     = y_q;
    to_d    = to_q;
    case (state_q)
      IDLE: if (req_valid) begin
        state_d = ISSUE;
        a_d     = req_a;
        b_d     = req_b;
      end
      ISSUE: begin
        state_d = WAIT;
        cnt_d   = '0;
      end
      WAIT: begin
        cnt_d = cnt_q + 8'd1;
        // a result arriving on the timeout cycle still wins
        if (dut_valid) begin
          y_d     = dut_y;
          to_d    = 1'b0;
          state_d = RESP;
        end else if (cnt_q == 8'(TIMEOUT - 1)) begin
          y_d     = '0;
          to_d    = 1'b1;
          state_d = RESP;
        end
      end
      RESP: if (rsp_ready) begin
        state_d = IDLE;
        txn_d   = txn_q + 8'd1;
      end
    endcase
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      txn_q   <= '0;
      a_q     <= '0;
      b_q     <= '0;
      y_q     <= '0;
      to_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      txn_q   <= txn_d;
      a_q     <= a_d;
      b_q     <= b_d;
      y_q     <= y_d;
      to_q    <= to_d;
    end
  end
  assign req_ready   = state_q == IDLE;
  assign busy        = state_q != IDLE;
  assign dut_start   = state_q == ISSUE;
  assign rsp_valid   = state_q == RESP;
  assign dut_a       = a_q;
  assign dut_b       = b_q;
  assign rsp_y       = y_q;
  assign rsp_timeout = to_q;
  assign txn_count   = txn_q;
endmodule

// File: tb/tb_design_36_host.sv
// tb_design_36_host: directed checks of the design_36_host handshake, timeout, backpressure, reset and counter wrap
module tb_design_36_host;
  logic clk = 1'b0, rst_n = 1'b0;
  logic req_valid = 1'b0, dut_valid = 1'b0, rsp_ready = 1'b0;
  logic [9:0] req_a = '0, req_b = '0, dut_y = '0;
  logic req_ready, dut_start, rsp_valid, rsp_timeout, busy;
  logic [9:0] dut_a, dut_b, rsp_y;
  logic [7:0] txn_count;
  int n_chk = 0, n_err = 0;

  design_36_host #(.W(10), .TIMEOUT(15)) dut (
    .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_ready(req_ready),
    .req_a(req_a), .req_b(req_b), .dut_start(dut_start), .dut_a(dut_a), .dut_b(dut_b),
    .dut_y(dut_y), .dut_valid(dut_valid), .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
    .rsp_y(rsp_y), .rsp_timeout(rsp_timeout), .busy(busy), .txn_count(txn_count)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic accept(input logic [9:0] a, input logic [9:0] b);
    req_valid = 1'b1;
    req_a = a;
    req_b = b;
    tick();
    req_valid = 1'b0;
  endtask

  initial begin
    int cyc;
    tick();
    tick();
    chk("rst_ready", req_ready, 1);
    chk("rst_busy", busy, 0);
    chk("rst_rsp_valid", rsp_valid, 0);
    chk("rst_start", dut_start, 0);
    chk("rst_dut_a", dut_a, 0);
    chk("rst_rsp_y", rsp_y, 0);
    chk("rst_txn", txn_count, 0);
    rst_n = 1'b1;
    tick();
    chk("post_rst_ready", req_ready, 1);
    chk("post_rst_busy", busy, 0);

    // basic: 3 + 5, result two cycles after start
    accept(10'd3, 10'd5);
    chk("basic_start", dut_start, 1);
    chk("basic_ready", req_ready, 0);
    chk("basic_dut_a", dut_a, 3);
    chk("basic_dut_b", dut_b, 5);
    tick();
    chk("basic_start_pulse", dut_start, 0);
    chk("basic_busy", busy, 1);
    tick();
    dut_valid = 1'b1;
    dut_y = 10'd8;
    tick();
    dut_valid = 1'b0;
    chk("basic_rsp_valid", rsp_valid, 1);
    chk("basic_rsp_y", rsp_y, 8);
    chk("basic_timeout", rsp_timeout, 0);
    chk("basic_hold_a", dut_a, 3);
    chk("basic_hold_b", dut_b, 5);
    rsp_ready = 1'b1;
    tick();
    rsp_ready = 1'b0;
    chk("basic_idle", busy, 0);
    chk("basic_txn", txn_count, 1);

    // timeout, then backpressure on the timeout response
    accept(10'd100, 10'd200);
    tick();
    cyc = 0;
    while (!rsp_valid && cyc < 40) begin
      tick();
      cyc++;
    end
    chk("to_latency", cyc, 15);
    chk("to_rsp_y", rsp_y, 0);
    chk("to_flag", rsp_timeout, 1);
    req_valid = 1'b1;
    req_a = 10'd7;
    req_b = 10'd9;
    dut_valid = 1'b1;
    dut_y = 10'h55;
    for (int i = 0; i < 10; i++) begin
      tick();
      chk("bp_rsp_valid", rsp_valid, 1);
      chk("bp_rsp_y", rsp_y, 0);
      chk("bp_timeout", rsp_timeout, 1);
      chk("bp_ready", req_ready, 0);
      chk("bp_dut_a", dut_a, 100);
    end
    req_valid = 1'b0;
    dut_valid = 1'b0;
    rsp_ready = 1'b1;
    tick();
    rsp_ready = 1'b0;
    chk("to_txn", txn_count, 2);
    chk("to_idle", busy, 0);
    chk("to_dut_b_idle", dut_b, 200);

    // result on the timeout cycle wins
    accept(10'd1, 10'd2);
    tick();
    for (int i = 0; i < 14; i++) tick();
    chk("sim_not_yet", rsp_valid, 0);
    dut_valid = 1'b1;
    dut_y = 10'h2A;
    tick();
    dut_valid = 1'b0;
    chk("sim_rsp_valid", rsp_valid, 1);
    chk("sim_rsp_y", rsp_y, 10'h2A);
    chk("sim_timeout", rsp_timeout, 0);
    rsp_ready = 1'b1;
    tick();
    rsp_ready = 1'b0;
    chk("sim_txn", txn_count, 3);

    // reset while waiting
    accept(10'd11, 10'd22);
    tick();
    tick();
    rst_n = 1'b0;
    #1;
    chk("mid_rst_busy", busy, 0);
    chk("mid_rst_ready", req_ready, 1);
    chk("mid_rst_dut_a", dut_a, 0);
    chk("mid_rst_rsp_y", rsp_y, 0);
    chk("mid_rst_txn", txn_count, 0);
    tick();
    tick();
    rst_n = 1'b1;
    dut_valid = 1'b1;
    dut_y = 10'h77;
    tick();
    tick();
    dut_valid = 1'b0;
    chk("late_valid_busy", busy, 0);
    chk("late_valid_rsp", rsp_valid, 0);
    chk("late_valid_y", rsp_y, 0);
    chk("late_valid_txn", txn_count, 0);

    // 256 quick transactions wrap the counter
    for (int i = 0; i < 256; i++) begin
      accept(10'(i), 10'(i + 1));
      tick();
      dut_valid = 1'b1;
      dut_y = 10'(i + 3);
      tick();
      dut_valid = 1'b0;
      rsp_ready = 1'b1;
      tick();
      rsp_ready = 1'b0;
      if (i == 254) chk("wrap_255", txn_count, 255);
    end
    chk("wrap_0", txn_count, 0);
    chk("wrap_last_y", rsp_y, 10'd258);
    dut_valid = 1'b1;
    dut_y = 10'h3FF;
    tick();
    dut_valid = 1'b0;
    chk("spur_busy", busy, 0);
    chk("spur_ready", req_ready, 1);
    chk("spur_rsp_y", rsp_y, 10'd258);
    chk("spur_txn", txn_count, 0);

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end
endmodule
